// File: rtl/dqs_tx_pkg.sv
// Shared types and widths for the DQS write sequencer and its loopback checker.
// Combinational definitions only; no latency, no backpressure.
package dqs_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_BURST = 2'd2,
    ST_POST  = 2'd3
  } dqs_tx_state_t;

  localparam int PP_CNT_W   = 8;
  localparam int MISMATCH_W = 8;

endpackage

// File: rtl/dqs_loopback_checker.sv
// Compares returned DQS against the driven level delayed by CHECK_DELAY cycles; saturating count.
// Count is visible one cycle after the compared sample; no backpressure.
module dqs_loopback_checker
  import dqs_tx_pkg::*;
#(
  parameter int CHECK_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  dqs_data,
  input  logic                  in_burst,
  input  logic                  dqs_received,
  output logic [MISMATCH_W-1:0] mismatch_cnt
);

  // Each stage holds {in_burst, dqs_data}.
  logic [1:0]            sr_q [CHECK_DELAY];
  logic [1:0]            sr_d [CHECK_DELAY];
  logic [MISMATCH_W-1:0] cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < CHECK_DELAY; i++) sr_d[i] = sr_q[i];
    sr_d[0] = {in_burst, dqs_data};
    for (int i = 1; i < CHECK_DELAY; i++) sr_d[i] = sr_q[i-1];

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (sr_q[CHECK_DELAY-1][1] && (dqs_received != sr_q[CHECK_DELAY-1][0])
                 && (cnt_q != {MISMATCH_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHECK_DELAY; i++) sr_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < CHECK_DELAY; i++) sr_q[i] <= sr_d[i];
      cnt_q <= cnt_d;
    end
  end

  assign mismatch_cnt = cnt_q;

endmodule

// File: rtl/dqs_tx_seq.sv
// Write DQS sequencer: preamble, toggling burst, postamble, then release; all outputs registered.
// Outputs change one cycle after acceptance; start outside IDLE is dropped. Optional checker: DQS_TX_LOOPBACK_CHECK_EN.
module dqs_tx_seq
  import dqs_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN  = 2,
  parameter int POSTAMBLE_LEN = 1,
  parameter int LEN_WIDTH     = 8,
  parameter int CHECK_DELAY   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  dqs_data,
  output logic                  dqs_tri,
  input  logic                  dqs_received,
  output logic [MISMATCH_W-1:0] mismatch_cnt
);

  localparam int CNT_W = (LEN_WIDTH > PP_CNT_W) ? LEN_WIDTH : PP_CNT_W;

  dqs_tx_state_t        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dqs_data_q, dqs_data_d;
  logic                 dqs_tri_q, dqs_tri_d;
  logic                 accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (burst_len != '0)) begin
          accept  = 1'b1;
          len_d   = burst_len;
          cnt_d   = CNT_W'(PREAMBLE_LEN - 1);
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(len_q) - CNT_W'(1);
          state_d = ST_BURST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BURST: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(POSTAMBLE_LEN - 1);
          state_d = ST_POST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_POST: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    dqs_tri_d  = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_q == ST_POST) && (state_d == ST_IDLE);
    dqs_data_d = 1'b0;
    if (state_d == ST_BURST) dqs_data_d = (state_q == ST_BURST) ? ~dqs_data_q : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dqs_data_q <= 1'b0;
      dqs_tri_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dqs_data_q <= dqs_data_d;
      dqs_tri_q  <= dqs_tri_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dqs_data = dqs_data_q;
  assign dqs_tri  = dqs_tri_q;

`ifdef DQS_TX_LOOPBACK_CHECK_EN
  dqs_loopback_checker #(
    .CHECK_DELAY (CHECK_DELAY)
  ) u_checker (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (accept),
    .dqs_data     (dqs_data_q),
    .in_burst     (state_q == ST_BURST),
    .dqs_received (dqs_received),
    .mismatch_cnt (mismatch_cnt)
  );
`else
  localparam int unused_check_delay = CHECK_DELAY;
  logic unused_rx;
  logic unused_accept;
  assign unused_rx     = dqs_received;
  assign unused_accept = accept;
  assign mismatch_cnt  = '0;
`endif

endmodule

// File: tb/tb_dqs_tx_seq.sv
module tb_dqs_tx_seq;

  localparam int PRE  = 2;
  localparam int POST = 1;
`ifdef DQS_TX_LOOPBACK_CHECK_EN
  localparam int EXP_INV = 6;
`else
  localparam int EXP_INV = 0;
`endif

  typedef struct packed {
    logic t;
    logic d;
    logic b;
    logic dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] burst_len;
  logic       busy, done, dqs_data, dqs_tri, dqs_received;
  logic [7:0] mismatch_cnt;
  logic       lb1, lb2, inv;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Loopback channel: two-cycle delay, optionally inverted.
  always @(posedge clk) begin
    lb1 <= dqs_data;
    lb2 <= lb1;
  end
  assign dqs_received = lb2 ^ inv;

  dqs_tx_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .burst_len    (burst_len),
    .busy         (busy),
    .done         (done),
    .dqs_data     (dqs_data),
    .dqs_tri      (dqs_tri),
    .dqs_received (dqs_received),
    .mismatch_cnt (mismatch_cnt)
  );

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back('{t:1'b1, d:1'b0, b:1'b0, dn:1'b0});
  endtask

  task automatic push_pre();
    for (int i = 0; i < PRE; i++) q.push_back('{t:1'b0, d:1'b0, b:1'b1, dn:1'b0});
  endtask

  task automatic push_burst(input int len);
    push_pre();
    for (int i = 0; i < len; i++) q.push_back('{t:1'b0, d:((i % 2) == 0), b:1'b1, dn:1'b0});
    for (int i = 0; i < POST; i++) q.push_back('{t:1'b0, d:1'b0, b:1'b1, dn:1'b0});
    q.push_back('{t:1'b1, d:1'b0, b:1'b0, dn:1'b1});
  endtask

  // Pops one expected cycle per clock; start is dropped after entry drop_at.
  task automatic run_queue(input string tag, input int drop_at);
    exp_t e;
    int   i;
    i = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      chk($sformatf("%s[%0d].tri", tag, i),  {7'd0, dqs_tri},  {7'd0, e.t});
      chk($sformatf("%s[%0d].data", tag, i), {7'd0, dqs_data}, {7'd0, e.d});
      chk($sformatf("%s[%0d].busy", tag, i), {7'd0, busy},     {7'd0, e.b});
      chk($sformatf("%s[%0d].done", tag, i), {7'd0, done},     {7'd0, e.dn});
      if (i == drop_at) begin
        start     = 1'b0;
        burst_len = 8'd9;
      end
      i++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; burst_len = 8'd0; inv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.tri", {7'd0, dqs_tri}, 8'd1);
    chk("rst.data", {7'd0, dqs_data}, 8'd0);
    chk("rst.busy", {7'd0, busy}, 8'd0);
    chk("rst.done", {7'd0, done}, 8'd0);
    chk("rst.mcnt", mismatch_cnt, 8'd0);
    rst_n = 1'b1;

    // Single burst of 4; burst_len changed after acceptance.
    start = 1'b1; burst_len = 8'd4;
    push_burst(4); push_idle(2);
    run_queue("b4", 0);

    // Zero-length request is ignored.
    start = 1'b1; burst_len = 8'd0;
    push_idle(3);
    run_queue("len0", 2);

    // start held: second burst accepted in the done cycle.
    start = 1'b1; burst_len = 8'd3;
    push_burst(3); push_burst(3); push_idle(1);
    run_queue("b2b", 7);

    // Reset during BURST of a length-10 burst.
    start = 1'b1; burst_len = 8'd10;
    push_pre();
    for (int i = 0; i < 3; i++) q.push_back('{t:1'b0, d:((i % 2) == 0), b:1'b1, dn:1'b0});
    run_queue("b10", 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst.tri", {7'd0, dqs_tri}, 8'd1);
    chk("mrst.busy", {7'd0, busy}, 8'd0);
    chk("mrst.done", {7'd0, done}, 8'd0);
    chk("mrst.data", {7'd0, dqs_data}, 8'd0);
    chk("mrst.mcnt", mismatch_cnt, 8'd0);
    rst_n = 1'b1;
    push_idle(2);
    run_queue("mrst_idle", -1);
    start = 1'b1; burst_len = 8'd1;
    push_burst(1);
    run_queue("after_rst", 0);

    // Loopback: matching, then inverted, then cleared by the next start.
    inv = 1'b0; start = 1'b1; burst_len = 8'd6;
    push_burst(6); push_idle(1);
    run_queue("lb_ok", 0);
    chk("lb_ok.mcnt", mismatch_cnt, 8'd0);

    inv = 1'b1; start = 1'b1; burst_len = 8'd6;
    push_burst(6); push_idle(1);
    run_queue("lb_inv", 0);
    chk("lb_inv.mcnt", mismatch_cnt, 8'(EXP_INV));

    inv = 1'b0; start = 1'b1; burst_len = 8'd2;
    push_burst(2); push_idle(1);
    run_queue("lb_clr", 0);
    chk("lb_clr.mcnt", mismatch_cnt, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
